// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, registered syncs, visible-area
// flag, line/frame start pulses and a wrapping frame counter.
module vga_sync_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    // Compare in int so a window ending exactly at 1024 cannot wrap to zero.
    function automatic logic in_window(logic [9:0] pos, int lo, int hi);
        return (int'(pos) >= lo) && (int'(pos) < hi);
    endfunction

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // NOTE: every variable in this block is assigned on every path, so no latch is inferred.
    always_comb begin
        h_wrap = (hpos == H_MAX);
        v_wrap = (vpos == V_MAX);
        h_next = h_wrap ? 10'd0 : hpos + 10'd1;
        v_next = vpos;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vpos + 10'd1;
        end
    end

    // Decoded outputs are registered from the next counter values, so they line up
    // with the hpos/vpos presented on the same cycle.
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos        <= '0;
            vpos        <= '0;
            frame_cnt   <= '0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            display_on  <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hpos        <= h_next;
            vpos        <= v_next;
            if (h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            hsync       <= in_window(h_next, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= in_window(v_next, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            display_on  <= in_window(h_next, 0, H_DISPLAY) && in_window(v_next, 0, V_DISPLAY);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
